decompressor: RTL and testbench
===============================

DECOMPRESSOR -- requirements
Module: decompressor

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 in_valid  input  1  compressed word offered.
REQ-004 in_data  input  64  compressed word: group g (0..4) at [12g+3:12g] = zero run Z (0-15), [12g+11:12g+4] = value V; [62:60] = group count N (0-5); [63] = tail flag T.
REQ-005 in_ready  output  1  word accepted when in_valid & in_ready.
REQ-006 flush  input  1  request to emit a partially filled output beat.
REQ-007 out_data  output  16x8  expanded bytes; byte 0 is the oldest.
REQ-008 out_valid_num  output  5  valid bytes in out_data (1-16), low-aligned.
REQ-009 out_valid  output  1  beat offered; transfer on out_valid & out_ready.
REQ-010 out_ready  input  1  downstream accepts beat.

Function
REQ-011 Group g expands to Z zero bytes followed by V; V is emitted iff g < N-1, or g == N-1 and T=1.
REQ-012 Groups with g >= N are ignored; N > 5 is treated as 5.
REQ-013 Byte order is preserved: group 0 first, zeros before value, words in acceptance order.
REQ-014 State machine IDLE / EXPAND / EMIT. in_ready=1 only in IDLE with out_valid=0.
REQ-015 IDLE, word accepted with N=0: word dropped, remain IDLE.
REQ-016 IDLE, word accepted with N>0: latch word; grp=0; rem=Z0; vpend=value-present(0); go to EXPAND next cycle.
REQ-017 EXPAND, each cycle: write k=min(rem, 16-fill) zeros at fill; fill+=k; rem-=k.
REQ-018 EXPAND, same cycle: if rem reaches 0, vpend=1 and fill<16, write V at fill; fill+=1; clear vpend.
REQ-019 When group g is finished (rem=0, vpend=0): advance grp; load next Z/vpend. After the last valid group, return to IDLE.
REQ-020 When fill reaches 16: go to EMIT. Present out_valid=1, out_valid_num=16. Unfinished group state is retained.
REQ-021 EMIT: hold out_data, out_valid_num, out_valid stable until out_ready. On transfer: fill=0, buffer cleared to zero. Return to EXPAND if the group is unfinished or later groups remain, else IDLE.
REQ-022 Flush: sampled only in IDLE with no word accepted that cycle.
  - fill>0: enter EMIT with out_valid_num=fill; upper bytes zero.
  - fill=0: flush ignored.
REQ-023 A word arriving together with flush in IDLE is accepted; flush is ignored that cycle and must be held by the requester.
REQ-024 Throughput: one group, or one 16-byte boundary split, per EXPAND cycle. A word of N groups with no split takes N EXPAND cycles.
REQ-025 Arithmetic:
  - fill is 5 bits, 0-16; never exceeds 16.
  - rem is 4 bits.
  - A group with Z=0 and no value completes in one cycle with zero bytes written.
REQ-026 out_data, out_valid_num, out_valid are registered; no combinational path from in_* or out_ready to outputs.

Reset
REQ-027 On rst_n=0 at a clock edge:
  - state=IDLE; fill=0; grp=0; rem=0; vpend=0.
  - out_data=0, out_valid_num=0, out_valid=0; latched word cleared.
  - in_ready=1 from the first cycle after reset release.
REQ-028 Reset mid-EXPAND or mid-EMIT discards all partial data; no beat is emitted for it.

Verification
REQ-029 Single word N=1, T=1, Z0=3, V0=0xAB, then flush -> one beat: out_valid_num=4, bytes 00 00 00 AB.
REQ-030 Word N=5, T=1, all Z=15, V=0x11..0x55 (80 bytes).
  - Expect exactly 5 beats of 16 bytes, out_ready held high.
  - Beat 0 byte 15 = 0x11.
  - Each beat: 15 zeros then the group value.
REQ-031 Word N=2, T=0, Z0=0, V0=0x7F, Z1=2, then flush -> beat 7F 00 00, out_valid_num=3; V1 not emitted.
REQ-032 Backpressure: out_ready=0 for 10 cycles while the first beat is pending.
  - out_data and out_valid_num held stable.
  - in_ready=0 throughout.
  - No byte lost or duplicated once out_ready=1.
REQ-033 N=0 word -> no beat, fill unchanged. Flush with fill=0 -> no beat.
REQ-034 Reset asserted while EXPAND is mid-word -> next cycle:
  - out_valid=0, in_ready=1.
  - A subsequent N=1, Z0=0, V0=0x01 word plus flush yields one beat with out_valid_num=1, byte 0 = 0x01.

Source files
------------

// File: rtl/decompressor.sv
// Zero-run decompressor: expands up to five (zero-run, value) groups per 64-bit word
// into 16-byte output beats, with flush support for partially filled beats.
module decompressor (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [63:0]     in_data,
  output logic            in_ready,
  input  logic            flush,
  output logic [15:0][7:0] out_data,
  output logic [4:0]      out_valid_num,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, EMIT = 2'd2} state_t;

  state_t          state_q;
  logic [63:0]     word_q;
  logic [2:0]      grp_q;
  logic [2:0]      ngrp_q;
  logic            tail_q;
  logic [3:0]      rem_q;
  logic            vpend_q;
  logic [4:0]      fill_q;
  logic            active_q;
  logic [15:0][7:0] buf_q;
  logic [4:0]      num_q;
  logic            ovalid_q;

  logic [4:0] space_s, k_s, fill_n_s, fill_w_s;
  logic [3:0] rem_n_s;
  logic       vpend_n_s, wr_s, grp_done_s, last_s;
  logic [2:0] next_grp_s, in_n_s;

  function automatic logic [2:0] clamp_n(input logic [2:0] n);
    return (n > 3'd5) ? 3'd5 : n;
  endfunction

  function automatic logic [3:0] grp_z(input logic [63:0] w, input logic [2:0] g);
    case (g)
      3'd0:    return w[3:0];
      3'd1:    return w[15:12];
      3'd2:    return w[27:24];
      3'd3:    return w[39:36];
      3'd4:    return w[51:48];
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] grp_v(input logic [63:0] w, input logic [2:0] g);
    case (g)
      3'd0:    return w[11:4];
      3'd1:    return w[23:16];
      3'd2:    return w[35:28];
      3'd3:    return w[47:40];
      3'd4:    return w[59:52];
      default: return 8'd0;
    endcase
  endfunction

  // The value of the final valid group is only emitted when the tail flag is set.
  function automatic logic vpresent(input logic [2:0] g, input logic [2:0] n, input logic t);
    return ((g + 3'd1) < n) || (((g + 3'd1) == n) && t);
  endfunction

  assign in_n_s        = clamp_n(in_data[62:60]);
  assign in_ready      = (state_q == IDLE) && !ovalid_q;
  assign out_data      = buf_q;
  assign out_valid_num = num_q;
  assign out_valid     = ovalid_q;

  // Bytes above fill are always zero, so a zero run only advances fill.
  always_comb begin
    space_s    = 5'd16 - fill_q;
    k_s        = ({1'b0, rem_q} < space_s) ? {1'b0, rem_q} : space_s;
    rem_n_s    = rem_q - k_s[3:0];
    fill_n_s   = fill_q + k_s;
    vpend_n_s  = vpend_q;
    wr_s       = 1'b0;
    if ((rem_n_s == 4'd0) && vpend_q && (fill_n_s < 5'd16)) begin
      wr_s      = 1'b1;
      vpend_n_s = 1'b0;
    end else begin
      wr_s      = 1'b0;
    end
    fill_w_s   = fill_n_s + {4'd0, wr_s};
    grp_done_s = (rem_n_s == 4'd0) && !vpend_n_s;
    next_grp_s = grp_q + 3'd1;
    last_s     = grp_done_s && (next_grp_s >= ngrp_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      word_q   <= 64'd0;
      grp_q    <= 3'd0;
      ngrp_q   <= 3'd0;
      tail_q   <= 1'b0;
      rem_q    <= 4'd0;
      vpend_q  <= 1'b0;
      fill_q   <= 5'd0;
      active_q <= 1'b0;
      buf_q    <= 128'd0;
      num_q    <= 5'd0;
      ovalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (in_n_s != 3'd0) begin
              word_q   <= in_data;
              ngrp_q   <= in_n_s;
              tail_q   <= in_data[63];
              grp_q    <= 3'd0;
              rem_q    <= grp_z(in_data, 3'd0);
              vpend_q  <= vpresent(3'd0, in_n_s, in_data[63]);
              active_q <= 1'b1;
              state_q  <= EXPAND;
            end
          end else if (flush && (fill_q != 5'd0)) begin
            ovalid_q <= 1'b1;
            num_q    <= fill_q;
            state_q  <= EMIT;
          end
        end
        EXPAND: begin
          fill_q  <= fill_w_s;
          rem_q   <= rem_n_s;
          vpend_q <= vpend_n_s;
          if (wr_s) begin
            buf_q[fill_n_s[3:0]] <= grp_v(word_q, grp_q);
          end
          if (last_s) begin
            active_q <= 1'b0;
          end else if (grp_done_s) begin
            grp_q   <= next_grp_s;
            rem_q   <= grp_z(word_q, next_grp_s);
            vpend_q <= vpresent(next_grp_s, ngrp_q, tail_q);
          end
          if (fill_w_s == 5'd16) begin
            ovalid_q <= 1'b1;
            num_q    <= 5'd16;
            state_q  <= EMIT;
          end else if (last_s) begin
            state_q  <= IDLE;
          end
        end
        EMIT: begin
          if (out_ready) begin
            ovalid_q <= 1'b0;
            num_q    <= 5'd0;
            fill_q   <= 5'd0;
            buf_q    <= 128'd0;
            state_q  <= active_q ? EXPAND : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decompressor.sv
// Scoreboard bench for decompressor: a byte-stream reference model predicts beats,
// a monitor pops and compares each transferred beat and checks backpressure holding.
module tb_decompressor;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [63:0]      in_data = 64'd0;
  logic             in_ready;
  logic             flush = 1'b0;
  logic [15:0][7:0] out_data;
  logic [4:0]       out_valid_num;
  logic             out_valid;
  logic             out_ready = 1'b1;

  decompressor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .out_data(out_data), .out_valid_num(out_valid_num),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] d; logic [4:0] n; } beat_t;
  beat_t      expq[$];
  logic [7:0] pend[$];
  int total = 0;
  int bad = 0;
  int beats_seen = 0;
  int bp_mode = 1;  // 0 random, 1 ready high, 2 ready low

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkw(input int n, input logic t, input logic [19:0] zs, input logic [39:0] vs);
    logic [63:0] w;
    w = 64'd0;
    w[63] = t;
    w[62:60] = n[2:0];
    for (int g = 0; g < 5; g++) begin
      w[12*g +: 4] = zs[4*g +: 4];
      w[12*g+4 +: 8] = vs[8*g +: 8];
    end
    return w;
  endfunction

  function automatic void push_byte(input logic [7:0] b);
    beat_t bt;
    pend.push_back(b);
    if (pend.size() == 16) begin
      bt.d = 128'd0;
      for (int i = 0; i < 16; i++) bt.d[8*i +: 8] = pend[i];
      bt.n = 5'd16;
      expq.push_back(bt);
      pend.delete();
    end
  endfunction

  function automatic void model_word(input logic [63:0] w);
    int n;
    n = (w[62:60] > 3'd5) ? 5 : int'(w[62:60]);
    for (int g = 0; g < n; g++) begin
      for (int z = 0; z < int'(w[12*g +: 4]); z++) push_byte(8'h00);
      if ((g < n - 1) || w[63]) push_byte(w[12*g+4 +: 8]);
    end
  endfunction

  function automatic void model_flush();
    beat_t bt;
    if (pend.size() > 0) begin
      bt.d = 128'd0;
      for (int i = 0; i < pend.size(); i++) bt.d[8*i +: 8] = pend[i];
      bt.n = 5'(pend.size());
      expq.push_back(bt);
      pend.delete();
    end
  endfunction

  task automatic wait_idle();
    int c = 0;
    @(negedge clk);
    while (!in_ready && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL wait_idle timeout in_ready=%0b", in_ready);
    end
  endtask

  task automatic send_word(input logic [63:0] w);
    wait_idle();
    in_valid = 1'b1;
    in_data = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_word(w);
  endtask

  task automatic do_flush();
    wait_idle();
    model_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    @(negedge clk);
    while ((expq.size() != 0 || !in_ready) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("drain_empty", 128'(expq.size()), 128'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pend.delete();
    expq.delete();
  endtask

  // Downstream ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares transferred beats against the scoreboard and checks stall holding.
  initial begin
    beat_t e;
    logic stall_prev = 1'b0;
    logic [127:0] prev_d = 128'd0;
    logic [4:0] prev_n = 5'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", 128'(out_valid), 128'd1);
          chk("hold_data", out_data, prev_d);
          chk("hold_num", 128'(out_valid_num), 128'(prev_n));
        end
        if (out_valid) chk("in_ready_busy", 128'(in_ready), 128'd0);
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat num=%0d data=%h", out_valid_num, out_data);
          end else begin
            e = expq.pop_front();
            chk("beat_num", 128'(out_valid_num), 128'(e.n));
            chk("beat_data", out_data, e.d);
          end
          beats_seen++;
        end
        stall_prev = out_valid && !out_ready;
        prev_d = out_data;
        prev_n = out_valid_num;
      end
    end
  end

  initial begin
    int b0;
    logic [63:0] w;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_num", 128'(out_valid_num), 128'd0);
    chk("rst_data", out_data, 128'd0);
    chk("rst_ready", 128'(in_ready), 128'd1);

    // single group plus flush: 00 00 00 AB
    b0 = beats_seen;
    send_word(mkw(1, 1'b1, 20'h00003, 40'h00000000AB));
    do_flush();
    drain();
    chk("t029_beats", 128'(beats_seen - b0), 128'd1);

    // five full groups: five 16-byte beats
    b0 = beats_seen;
    send_word(mkw(5, 1'b1, 20'hFFFFF, 40'h5544332211));
    drain();
    chk("t030_beats", 128'(beats_seen - b0), 128'd5);

    // no tail: 7F 00 00, V1 dropped
    send_word(mkw(2, 1'b0, 20'h00020, 40'h000000997F));
    do_flush();
    drain();

    // N=0 word leaves fill alone; empty flush emits nothing
    send_word(mkw(1, 1'b1, 20'h00001, 40'h000000005A));
    send_word(mkw(0, 1'b1, 20'h33333, 40'h1234567890));
    do_flush();
    drain();
    b0 = beats_seen;
    send_word(mkw(0, 1'b1, 20'h11111, 40'hAAAAAAAAAA));
    do_flush();
    repeat (8) @(negedge clk);
    chk("t033_nobeat", 128'(beats_seen - b0), 128'd0);

    // backpressure on the first beat
    bp_mode = 2;
    send_word(mkw(5, 1'b1, 20'hFFFFF, 40'hEEDDCCBBAA));
    repeat (10) @(negedge clk);
    chk("t032_valid", 128'(out_valid), 128'd1);
    chk("t032_ready", 128'(in_ready), 128'd0);
    bp_mode = 1;
    drain();

    // reset mid-expand
    send_word(mkw(2, 1'b1, 20'h00033, 40'h0000002211));
    do_reset();
    @(negedge clk);
    chk("t034_valid", 128'(out_valid), 128'd0);
    chk("t034_ready", 128'(in_ready), 128'd1);
    b0 = beats_seen;
    send_word(mkw(1, 1'b1, 20'h00000, 40'h0000000001));
    do_flush();
    drain();
    chk("t034_beats", 128'(beats_seen - b0), 128'd1);

    // randomized traffic
    bp_mode = 0;
    for (int i = 0; i < 60; i++) begin
      w = {$urandom, $urandom};
      send_word(w);
      if ($urandom_range(0, 3) == 0) do_flush();
    end
    do_flush();
    bp_mode = 1;
    drain();
    chk("final_pend", 128'(pend.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
